banked_register_file: RTL and testbench

- Next-generation ARM general-purpose register file: replaces the fixed 3-read/1-write file with a parametrised read-port count, a second write port for base-register writeback (LDR/STR pre- and post-index), and optional same-cycle write-to-read bypass.
- Adds processor-mode register banking: R13/R14 are banked per mode and R8–R14 for FIQ.
- Sits between decode and execute. R15 is not stored; it is supplied by the fetch stage.

---
 rtl/banked_register_file.sv | 107 ++++++++++
 tb/tb_banked_register_file.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_register_file.sv
// Banked ARM general-purpose register file: NUM_READ combinational read ports,
// two write ports (result and base writeback), per-mode banking of R8-R14.
module banked_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_READ   = 3,
   parameter int BYPASS     = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [1:0]                     mode,
   input  logic [NUM_READ*4-1:0]          read_reg_addrs,
   output logic [NUM_READ*DATA_WIDTH-1:0] read_datas,
   input  logic                           write_enable3,
   input  logic [3:0]                     write_reg_addr3,
   input  logic [DATA_WIDTH-1:0]          write_data3,
   input  logic                           write_enable4,
   input  logic [3:0]                     write_reg_addr4,
   input  logic [DATA_WIDTH-1:0]          write_data4,
   input  logic [DATA_WIDTH-1:0]          r15
);

   localparam logic [1:0] MODE_USR = 2'd0;
   localparam logic [1:0] MODE_FIQ = 2'd1;
   localparam logic [1:0] MODE_IRQ = 2'd2;
   localparam logic [1:0] MODE_SVC = 2'd3;

   // Physical map: 0-7 R0-R7, 8-12 USR R8-R12, 13-17 FIQ R8-R12,
   // 18+2*mode R13 and 19+2*mode R14 (USR, FIQ, IRQ, SVC).
   // The ARM total of 31 also counts R15 and the ABT/UND banks, which the
   // 2-bit mode encoding cannot reach, so only 26 entries are stored here.
   localparam int NUM_PHYS = 26;

   logic [DATA_WIDTH-1:0] regs [NUM_PHYS];

   function automatic logic [4:0] phys_index(input logic [3:0] addr, input logic [1:0] m);
      logic [4:0] idx;
      if (addr < 4'd8) begin
         idx = {1'b0, addr};
      end else if (addr < 4'd13) begin
         idx = (m == MODE_FIQ) ? ({1'b0, addr} + 5'd5) : {1'b0, addr};
      end else begin
         // R13 has addr[1]=0, R14 has addr[1]=1; R15 lands in range but is masked by callers.
         idx = 5'd18 + {2'b00, m, 1'b0} + {4'b0000, addr[1]};
      end
      return idx;
   endfunction

   logic [4:0] phys3;
   logic [4:0] phys4;
   logic       commit3;
   logic       commit4;

   assign phys3   = phys_index(write_reg_addr3, mode);
   assign phys4   = phys_index(write_reg_addr4, mode);
   assign commit3 = write_enable3 && (write_reg_addr3 != 4'd15);
   assign commit4 = write_enable4 && (write_reg_addr4 != 4'd15);

   // NOTE: the register array is reset explicitly because every entry must read 0 after reset;
   // this keeps it in flops rather than a RAM macro, which is fine at this size.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PHYS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (commit4) begin
            regs[phys4] <= write_data4;
         end
         // Last non-blocking assignment wins, so port 3 overrides port 4 on a collision.
         if (commit3) begin
            regs[phys3] <= write_data3;
         end
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      logic [3:0]            addr;
      logic [4:0]            phys;
      logic [DATA_WIDTH-1:0] data;

      assign addr = read_reg_addrs[4*i +: 4];
      assign phys = phys_index(addr, mode);

      // NOTE: data gets a default first so no path through this block infers a latch.
      always_comb begin
         data = regs[phys];
         if (BYPASS != 0) begin
            if (commit4 && (phys4 == phys)) begin
               data = write_data4;
            end
            if (commit3 && (phys3 == phys)) begin
               data = write_data3;
            end
         end
         if (addr == 4'd15) begin
            data = r15;
         end
      end

      assign read_datas[DATA_WIDTH*i +: DATA_WIDTH] = data;
   end

   // Mode constants kept for readability of the encoding above.
   logic unused_modes;
   assign unused_modes = ^{MODE_USR, MODE_IRQ, MODE_SVC};

endmodule

// File: tb/tb_banked_register_file.sv
// Randomised and directed bench for banked_register_file, running a BYPASS=1
// and a BYPASS=0 instance side by side against a mode-keyed register model.
module tb_banked_register_file;

   logic        clk;
   logic        reset;
   logic [1:0]  mode;
   logic [3:0]  raddr [3];
   logic [11:0] read_reg_addrs;
   logic [95:0] rd_byp;
   logic [95:0] rd_nb;
   logic        we3, we4;
   logic [3:0]  a3, a4;
   logic [31:0] d3, d4;
   logic [31:0] r15;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [int];

   assign read_reg_addrs = {raddr[2], raddr[1], raddr[0]};

   banked_register_file #(.DATA_WIDTH(32), .NUM_READ(3), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .mode(mode),
      .read_reg_addrs(read_reg_addrs), .read_datas(rd_byp),
      .write_enable3(we3), .write_reg_addr3(a3), .write_data3(d3),
      .write_enable4(we4), .write_reg_addr4(a4), .write_data4(d4),
      .r15(r15));

   banked_register_file #(.DATA_WIDTH(32), .NUM_READ(3), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .mode(mode),
      .read_reg_addrs(read_reg_addrs), .read_datas(rd_nb),
      .write_enable3(we3), .write_reg_addr3(a3), .write_data3(d3),
      .write_enable4(we4), .write_reg_addr4(a4), .write_data4(d4),
      .r15(r15));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Identity of the storage a logical register names in a given mode.
   function automatic int key(input logic [3:0] addr, input logic [1:0] m);
      if (addr < 8)  return int'(addr);
      if (addr < 13) return (m == 2'd1) ? 100 + int'(addr) : int'(addr);
      return 1000 * (int'(m) + 1) + int'(addr);
   endfunction

   function automatic logic [31:0] stored(input int k);
      return model.exists(k) ? model[k] : 32'h0;
   endfunction

   function automatic logic [31:0] exp_read(input logic [3:0] addr, input bit byp);
      int k;
      if (addr == 4'd15) return r15;
      k = key(addr, mode);
      if (byp && we3 && a3 != 4'd15 && key(a3, mode) == k) return d3;
      if (byp && we4 && a4 != 4'd15 && key(a4, mode) == k) return d4;
      return stored(k);
   endfunction

   function automatic logic [31:0] port(input logic [95:0] bus, input int p);
      return bus[32*p +: 32];
   endfunction

   task automatic set_writes(input logic e3, input logic [3:0] x3, input logic [31:0] v3,
                             input logic e4, input logic [3:0] x4, input logic [31:0] v4);
      we3 = e3; a3 = x3; d3 = v3;
      we4 = e4; a4 = x4; d4 = v4;
   endtask

   task automatic set_reads(input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] x2);
      raddr[0] = x0; raddr[1] = x1; raddr[2] = x2;
   endtask

   task automatic peek();
      #1;
   endtask

   // Check every port of both instances, commit the writes to the model, advance one cycle.
   task automatic step();
      #1;
      for (int p = 0; p < 3; p++) begin
         check($sformatf("byp_p%0d_a%0d_m%0d", p, raddr[p], mode), port(rd_byp, p), exp_read(raddr[p], 1'b1));
         check($sformatf("nb_p%0d_a%0d_m%0d", p, raddr[p], mode), port(rd_nb, p), exp_read(raddr[p], 1'b0));
      end
      if (we4 && a4 != 4'd15) model[key(a4, mode)] = d4;
      if (we3 && a3 != 4'd15) model[key(a3, mode)] = d3;
      @(posedge clk);
      #1;
   endtask

   task automatic sweep();
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         for (int b = 0; b <= 12; b += 3) begin
            set_reads(4'(b), 4'(b + 1), 4'(b + 2));
            step();
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      mode  = 2'd0;
      r15   = 32'h0;
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      set_reads(4'd0, 4'd0, 4'd0);

      // Put something in the file, then reset asynchronously mid-cycle.
      @(posedge clk); #1;
      set_writes(1'b1, 4'd0, 32'h11111111, 1'b1, 4'd13, 32'h22222222);
      step();
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      set_reads(4'd0, 4'd7, 4'd13);
      #1 reset = 1'b0;
      model.delete();
      #1;
      for (int p = 0; p < 3; p++) begin
         check($sformatf("reset_byp_p%0d", p), port(rd_byp, p), 32'h0);
         check($sformatf("reset_nb_p%0d", p), port(rd_nb, p), 32'h0);
      end
      set_reads(4'd15, 4'd15, 4'd15);
      r15 = 32'h00000108;
      #1;
      check("reset_r15_p0", port(rd_byp, 0), 32'h00000108);
      check("reset_r15_p2", port(rd_nb, 2), 32'h00000108);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      set_reads(4'd0, 4'd7, 4'd13);
      step();

      // A write whose edge lands while reset is low must be lost.
      set_writes(1'b1, 4'd4, 32'h00000005, 1'b0, 4'd0, 32'h0);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      reset = 1'b1;
      set_reads(4'd4, 4'd4, 4'd4);
      peek();
      check("reset_wins_r4", port(rd_nb, 0), 32'h0);
      step();

      // Dual write and same-register collision.
      mode = 2'd0;
      set_writes(1'b1, 4'd1, 32'hDEADBEEF, 1'b1, 4'd2, 32'h00001000);
      set_reads(4'd1, 4'd2, 4'd5);
      step();
      set_writes(1'b1, 4'd5, 32'h00000001, 1'b1, 4'd5, 32'h00000002);
      peek();
      check("dual_r1", port(rd_nb, 0), 32'hDEADBEEF);
      check("dual_r2", port(rd_nb, 1), 32'h00001000);
      check("collide_bypass_r5", port(rd_byp, 2), 32'h00000001);
      step();
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      peek();
      check("collide_r5", port(rd_nb, 2), 32'h00000001);
      step();

      // Banking.
      mode = 2'd0; set_writes(1'b1, 4'd13, 32'hAAAA0000, 1'b0, 4'd0, 32'h0); step();
      mode = 2'd3; set_writes(1'b1, 4'd13, 32'hBBBB0000, 1'b0, 4'd0, 32'h0); step();
      mode = 2'd1; set_writes(1'b1, 4'd8,  32'hCCCC0000, 1'b0, 4'd0, 32'h0); step();
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      mode = 2'd0; set_reads(4'd13, 4'd8, 4'd15); peek();
      check("bank_usr_r13", port(rd_byp, 0), 32'hAAAA0000);
      check("bank_usr_r8", port(rd_byp, 1), 32'h0);
      step();
      mode = 2'd3; set_reads(4'd13, 4'd8, 4'd14); peek();
      check("bank_svc_r13", port(rd_byp, 0), 32'hBBBB0000);
      step();
      mode = 2'd1; set_reads(4'd8, 4'd13, 4'd14); peek();
      check("bank_fiq_r8", port(rd_byp, 0), 32'hCCCC0000);
      check("bank_fiq_r13", port(rd_byp, 1), 32'h0);
      step();

      // Same-cycle bypass versus next-cycle visibility.
      mode = 2'd0;
      set_writes(1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 32'h0);
      set_reads(4'd3, 4'd3, 4'd3);
      peek();
      check("bypass_same_cycle", port(rd_byp, 0), 32'h12345678);
      check("nobypass_same_cycle", port(rd_nb, 0), 32'h0);
      step();
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      peek();
      check("nobypass_next_cycle", port(rd_nb, 0), 32'h12345678);
      step();

      // R15: writes ignored, reads always return the fetch value.
      r15 = 32'h0;
      set_writes(1'b1, 4'd15, 32'hFFFFFFFF, 1'b1, 4'd15, 32'hFFFFFFFF);
      set_reads(4'd15, 4'd15, 4'd15);
      peek();
      for (int p = 0; p < 3; p++) check($sformatf("r15_byp_p%0d", p), port(rd_byp, p), 32'h0);
      step();
      sweep();

      // Rs operand port.
      mode = 2'd0;
      set_writes(1'b1, 4'd14, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0);
      step();
      set_writes(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      set_reads(4'd0, 4'd0, 4'd14);
      peek();
      check("rs_usr_r14", port(rd_nb, 2), 32'hFFFFFFFF);
      step();
      mode = 2'd2;
      peek();
      check("rs_irq_r14", port(rd_nb, 2), 32'h0);
      step();

      // Random traffic, with deliberate collisions and R15 accesses.
      for (int n = 0; n < 400; n++) begin
         mode = 2'($urandom_range(0, 3));
         r15  = $urandom;
         set_writes(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) == 0) a4 = a3;
         set_reads(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) raddr[$urandom_range(0, 2)] = a3;
         step();
      end
      sweep();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
